id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Decode stage with an internal register bank and a registered ID/EX output. Resolves
//  BEQ/BNE/J/JR in ID and detects load-use and branch-operand hazards, inserting bubbles.
//  Sits between the IF/ID register and the EX stage of the MIPS pipeline.
// PARAMETERS
//  REGISTERS_BANK_SIZE  32  number of GPRs; r0 reads 0, writes to r0 are ignored
//  PC_SIZE              32  width of PC values
//  BUS_SIZE             32  data/instruction width
// PORTS  (AW = $clog2(REGISTERS_BANK_SIZE))
//  i_clk            in   1   clock, rising edge
//  i_reset          in   1   asynchronous, active-high reset
//  i_valid          in   1   IF/ID holds a real instruction
//  i_stall          in   1   external freeze (debug unit): hold ID/EX, no branch
//  i_flush          in   1   load a bubble into ID/EX
//  i_instruction    in   BUS_SIZE  instruction in ID
//  i_next_seq_pc    in   PC_SIZE   PC+4 of that instruction
//  i_mem_reg_write  in   1   instruction in MEM writes a GPR
//  i_mem_dst        in   AW  its destination register
//  i_wb_write_en    in   1   WB write enable
//  i_wb_addr        in   AW  WB destination
//  i_wb_data        in   BUS_SIZE  WB data
//  o_hazard_stall   out  1   freeze PC and IF/ID this cycle (combinational)
//  o_branch_taken   out  1   redirect fetch (combinational)
//  o_branch_target  out  PC_SIZE   redirect address
//  o_ex_valid       out  1   ID/EX holds a real instruction
//  o_ex_bus_a/_b    out  BUS_SIZE  rs/rt operand values
//  o_ex_imm         out  BUS_SIZE  sign-extended imm[15:0]
//  o_ex_rs/_rt      out  AW  source register numbers
//  o_ex_dst         out  AW  resolved destination (rd for R-type, rt for I-type)
//  o_ex_funct       out  6   funct field
//  o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_alu_src  out 1 each
// BEHAVIOUR
//  - Reset: all GPRs 0, every ID/EX output 0; o_hazard_stall, o_branch_taken follow
//    their combinational equations (reset ID/EX is invalid, so no hazard from it).
//  - Decode: op 0x00 is R-type (writes rd; funct 0x08 = JR, no write). 0x23 LW
//    (read, writes rt). 0x2B SW. 0x04 BEQ, 0x05 BNE. 0x02 J. 0x08-0x0F I-type ALU
//    (writes rt, alu_src=1). Other opcodes decode as NOP: all controls 0.
//  - uses_rt: R-type, SW, BEQ, BNE. Writes to dst 0 clear reg_write.
//  - Load-use: o_ex_valid & o_ex_mem_read & o_ex_dst!=0 & (dst==rs | (uses_rt &
//    dst==rt)).
//  - Branch-operand: BEQ/BNE/JR reads a reg (rs, plus rt for BEQ/BNE) that is a
//    nonzero dst of ID/EX (reg_write) or of MEM (i_mem_reg_write).
//  - o_hazard_stall = i_valid & (load-use | branch-operand | bypass-miss; see
//    CONFIGURATION).
//  - Branch: BEQ taken if a==b, BNE if a!=b. Target is next_seq_pc + (imm<<2).
//    J: {next_seq_pc[31:28], dir, 2'b00}. JR: bus_a.
//  - o_branch_taken is gated by i_valid & ~o_hazard_stall & ~i_stall.
//  - ID/EX update per edge, priority high->low:
//    i_flush -> bubble; i_stall -> hold; o_hazard_stall or ~i_valid -> bubble;
//    otherwise load the decoded instruction.
//  - A bubble clears o_ex_valid and all control outputs; data fields are don't-care.
//  - Register bank: write on rising edge when i_wb_write_en & i_wb_addr!=0.
//  - Reset mid-operation clears everything immediately.
//  - Latency: ID/EX outputs are 1 cycle after the instruction is in ID; branch outputs
//    are 0-cycle (combinational).
// CONFIGURATION
//  ID_WB_BYPASS_EN defined: a same-cycle read of i_wb_addr (nonzero, write enabled)
//    returns i_wb_data, and bypass-miss is 0.
//  Undefined: reads return the old bank value, and bypass-miss = i_wb_write_en &
//    i_wb_addr!=0 & (addr==rs | (uses_rt & addr==rt)), costing one stall cycle.
// TESTING
//  1. Reset, then WB writes r1=5, r2=5; BEQ r1,r2,+3 at next_seq_pc 0x40 -> taken,
//     target 0x4C, ID/EX gets a BEQ with reg_write 0.
//  2. LW r3,0(r1) then ADD r4,r3,r1 -> one cycle o_hazard_stall=1, bubble
//     (o_ex_valid=0), then ADD loads with rs=3.
//  3. ADDI r5,r0,1 in EX, BNE r5,r0 in ID -> stall while r5 is in EX and in MEM, then
//     resolves. i_mem_reg_write=1, i_mem_dst=5 drives the MEM-stage stall.
//  4. WB writes r7=0xDEAD while ID reads r7: with ID_WB_BYPASS_EN, o_ex_bus_a=0xDEAD
//     next edge with no stall. Without it, 1 stall, then 0xDEAD.
//  5. i_flush and i_stall both high -> bubble. i_stall alone -> ID/EX held,
//     o_branch_taken=0 for J.
//  6. WB write to r0 with data 0xFFFF, then read r0 -> 0. Async reset mid-stream ->
//     o_ex_valid=0 at once.

Source files
------------

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register bank, branch resolution in ID, hazard detection and the ID/EX register.
// Build option: define ID_WB_BYPASS_EN to forward same-cycle WB writes into the ID operand reads.
module id_stage_pipe #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int PC_SIZE             = 32,
    parameter int BUS_SIZE            = 32,
    localparam int AW                 = $clog2(REGISTERS_BANK_SIZE)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [BUS_SIZE-1:0] i_instruction,
    input  logic [PC_SIZE-1:0]  i_next_seq_pc,
    input  logic                i_mem_reg_write,
    input  logic [AW-1:0]       i_mem_dst,
    input  logic                i_wb_write_en,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [BUS_SIZE-1:0] i_wb_data,
    output logic                o_hazard_stall,
    output logic                o_branch_taken,
    output logic [PC_SIZE-1:0]  o_branch_target,
    output logic                o_ex_valid,
    output logic [BUS_SIZE-1:0] o_ex_bus_a,
    output logic [BUS_SIZE-1:0] o_ex_bus_b,
    output logic [BUS_SIZE-1:0] o_ex_imm,
    output logic [AW-1:0]       o_ex_rs,
    output logic [AW-1:0]       o_ex_rt,
    output logic [AW-1:0]       o_ex_dst,
    output logic [5:0]          o_ex_funct,
    output logic                o_ex_reg_write,
    output logic                o_ex_mem_read,
    output logic                o_ex_mem_write,
    output logic                o_ex_alu_src
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    logic [5:0]          op;
    logic [5:0]          funct;
    logic [AW-1:0]       rs;
    logic [AW-1:0]       rt;
    logic [AW-1:0]       rd;
    logic [15:0]         imm16;
    logic [25:0]         dir;
    logic [BUS_SIZE-1:0] imm_ext;

    assign op      = i_instruction[31:26];
    assign rs      = i_instruction[21 +: AW];
    assign rt      = i_instruction[16 +: AW];
    assign rd      = i_instruction[11 +: AW];
    assign imm16   = i_instruction[15:0];
    assign funct   = i_instruction[5:0];
    assign dir     = i_instruction[25:0];
    assign imm_ext = {{(BUS_SIZE-16){imm16[15]}}, imm16};

    logic          dec_reg_write;
    logic          dec_mem_read;
    logic          dec_mem_write;
    logic          dec_alu_src;
    logic          dec_uses_rt;
    logic          dec_beq;
    logic          dec_bne;
    logic          dec_j;
    logic          dec_jr;
    logic [AW-1:0] dec_dst;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_uses_rt   = 1'b0;
        dec_beq       = 1'b0;
        dec_bne       = 1'b0;
        dec_j         = 1'b0;
        dec_jr        = 1'b0;
        dec_dst       = rt;
        case (op)
            OP_RTYPE: begin
                dec_dst     = rd;
                dec_uses_rt = 1'b1;
                if (funct == FUNCT_JR) begin
                    dec_jr = 1'b1;
                end else begin
                    dec_reg_write = 1'b1;
                end
            end
            OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec_beq     = 1'b1;
                dec_uses_rt = 1'b1;
            end
            OP_BNE: begin
                dec_bne     = 1'b1;
                dec_uses_rt = 1'b1;
            end
            OP_J: begin
                dec_j = 1'b1;
            end
            default: begin
                // 0x08-0x0F immediate ALU group; anything else stays a NOP
                if (op[5:3] == 3'b001) begin
                    dec_reg_write = 1'b1;
                    dec_alu_src   = 1'b1;
                end
            end
        endcase
        if (dec_dst == '0) begin
            dec_reg_write = 1'b0;
        end
    end

    logic [BUS_SIZE-1:0] regs [REGISTERS_BANK_SIZE];
    logic                wb_hit;

    assign wb_hit = i_wb_write_en && (i_wb_addr != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[i_wb_addr] <= i_wb_data;
        end
    end

    logic [BUS_SIZE-1:0] bus_a;
    logic [BUS_SIZE-1:0] bus_b;
    logic                bypass_miss;

`ifdef ID_WB_BYPASS_EN
    always_comb begin
        bus_a = regs[rs];
        bus_b = regs[rt];
        if (wb_hit && (i_wb_addr == rs)) begin
            bus_a = i_wb_data;
        end
        if (wb_hit && (i_wb_addr == rt)) begin
            bus_b = i_wb_data;
        end
    end

    assign bypass_miss = 1'b0;
`else
    assign bus_a = regs[rs];
    assign bus_b = regs[rt];

    // Bank is written at the edge, so an operand being written this cycle is stale here.
    assign bypass_miss = wb_hit &&
                         ((i_wb_addr == rs) || (dec_uses_rt && (i_wb_addr == rt)));
`endif

    logic load_use;
    logic ex_conflict;
    logic mem_conflict;
    logic branch_operand;
    logic is_cond_branch;

    assign is_cond_branch = dec_beq || dec_bne;

    assign load_use = o_ex_valid && o_ex_mem_read && (o_ex_dst != '0) &&
                      ((o_ex_dst == rs) || (dec_uses_rt && (o_ex_dst == rt)));

    // Branches compare in ID, so any in-flight producer of their operands must drain first.
    assign ex_conflict = o_ex_valid && o_ex_reg_write && (o_ex_dst != '0) &&
                         ((o_ex_dst == rs) || (is_cond_branch && (o_ex_dst == rt)));

    assign mem_conflict = i_mem_reg_write && (i_mem_dst != '0) &&
                          ((i_mem_dst == rs) || (is_cond_branch && (i_mem_dst == rt)));

    assign branch_operand = (is_cond_branch || dec_jr) && (ex_conflict || mem_conflict);

    assign o_hazard_stall = i_valid && (load_use || branch_operand || bypass_miss);

    logic               operands_equal;
    logic               taken_raw;
    logic [PC_SIZE-1:0] branch_offset;

    assign operands_equal = (bus_a == bus_b);
    assign taken_raw      = (dec_beq && operands_equal) || (dec_bne && !operands_equal) ||
                            dec_j || dec_jr;
    assign branch_offset  = {{(PC_SIZE-18){imm16[15]}}, imm16, 2'b00};
    assign o_branch_taken = i_valid && !o_hazard_stall && !i_stall && taken_raw;

    always_comb begin
        if (dec_j) begin
            o_branch_target = {i_next_seq_pc[PC_SIZE-1:28], dir, 2'b00};
        end else if (dec_jr) begin
            o_branch_target = PC_SIZE'(bus_a);
        end else begin
            o_branch_target = i_next_seq_pc + branch_offset;
        end
    end

    logic load_bubble;

    assign load_bubble = o_hazard_stall || !i_valid;

    // Bubbles only clear valid and controls; data fields are left as whatever was decoded.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ex_valid     <= 1'b0;
            o_ex_bus_a     <= '0;
            o_ex_bus_b     <= '0;
            o_ex_imm       <= '0;
            o_ex_rs        <= '0;
            o_ex_rt        <= '0;
            o_ex_dst       <= '0;
            o_ex_funct     <= '0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
            o_ex_alu_src   <= 1'b0;
        end else if (i_flush || (!i_stall && load_bubble)) begin
            o_ex_valid     <= 1'b0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
            o_ex_alu_src   <= 1'b0;
        end else if (!i_stall) begin
            o_ex_valid     <= 1'b1;
            o_ex_bus_a     <= bus_a;
            o_ex_bus_b     <= bus_b;
            o_ex_imm       <= imm_ext;
            o_ex_rs        <= rs;
            o_ex_rt        <= rt;
            o_ex_dst       <= dec_dst;
            o_ex_funct     <= funct;
            o_ex_reg_write <= dec_reg_write;
            o_ex_mem_read  <= dec_mem_read;
            o_ex_mem_write <= dec_mem_write;
            o_ex_alu_src   <= dec_alu_src;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected ID/EX contents are queued when each instruction
// is driven and checked one edge later; branch/hazard outputs are checked mid-cycle.
module tb_id_stage_pipe;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_instruction;
    logic [31:0] i_next_seq_pc;
    logic        i_mem_reg_write;
    logic [4:0]  i_mem_dst;
    logic        i_wb_write_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_hazard_stall;
    logic        o_branch_taken;
    logic [31:0] o_branch_target;
    logic        o_ex_valid;
    logic [31:0] o_ex_bus_a;
    logic [31:0] o_ex_bus_b;
    logic [31:0] o_ex_imm;
    logic [4:0]  o_ex_rs;
    logic [4:0]  o_ex_rt;
    logic [4:0]  o_ex_dst;
    logic [5:0]  o_ex_funct;
    logic        o_ex_reg_write;
    logic        o_ex_mem_read;
    logic        o_ex_mem_write;
    logic        o_ex_alu_src;

    id_stage_pipe dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_instruction   (i_instruction),
        .i_next_seq_pc   (i_next_seq_pc),
        .i_mem_reg_write (i_mem_reg_write),
        .i_mem_dst       (i_mem_dst),
        .i_wb_write_en   (i_wb_write_en),
        .i_wb_addr       (i_wb_addr),
        .i_wb_data       (i_wb_data),
        .o_hazard_stall  (o_hazard_stall),
        .o_branch_taken  (o_branch_taken),
        .o_branch_target (o_branch_target),
        .o_ex_valid      (o_ex_valid),
        .o_ex_bus_a      (o_ex_bus_a),
        .o_ex_bus_b      (o_ex_bus_b),
        .o_ex_imm        (o_ex_imm),
        .o_ex_rs         (o_ex_rs),
        .o_ex_rt         (o_ex_rt),
        .o_ex_dst        (o_ex_dst),
        .o_ex_funct      (o_ex_funct),
        .o_ex_reg_write  (o_ex_reg_write),
        .o_ex_mem_read   (o_ex_mem_read),
        .o_ex_mem_write  (o_ex_mem_write),
        .o_ex_alu_src    (o_ex_alu_src)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        chk_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic rw, input logic mr, input logic mw,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        e.tag = tag; e.valid = 1'b1; e.rw = rw; e.mr = mr; e.mw = mw; e.chk_data = 1'b1;
        e.rs = rs; e.rt = rt; e.dst = dst; e.a = a; e.b = b; e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        exp_t e;
        e.tag = tag; e.valid = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.chk_data = 1'b0;
        e.rs = '0; e.rt = '0; e.dst = '0; e.a = '0; e.b = '0; e.imm = '0;
        sb.push_back(e);
    endtask

    task automatic comb(input string tag, input logic hz, input logic bt,
                        input logic chk_tgt, input logic [31:0] tgt);
        @(negedge i_clk);
        chk({tag, "_hazard"}, 32'(o_hazard_stall), 32'(hz));
        chk({tag, "_taken"}, 32'(o_branch_taken), 32'(bt));
        if (chk_tgt) chk({tag, "_target"}, o_branch_target, tgt);
    endtask

    task automatic step();
        exp_t e;
        @(posedge i_clk);
        #1;
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=0 expected=1 entries");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_valid"}, 32'(o_ex_valid), 32'(e.valid));
        chk({e.tag, "_reg_write"}, 32'(o_ex_reg_write), 32'(e.rw));
        chk({e.tag, "_mem_read"}, 32'(o_ex_mem_read), 32'(e.mr));
        chk({e.tag, "_mem_write"}, 32'(o_ex_mem_write), 32'(e.mw));
        if (e.chk_data) begin
            chk({e.tag, "_rs"}, 32'(o_ex_rs), 32'(e.rs));
            chk({e.tag, "_rt"}, 32'(o_ex_rt), 32'(e.rt));
            chk({e.tag, "_dst"}, 32'(o_ex_dst), 32'(e.dst));
            chk({e.tag, "_bus_a"}, o_ex_bus_a, e.a);
            chk({e.tag, "_bus_b"}, o_ex_bus_b, e.b);
            chk({e.tag, "_imm"}, o_ex_imm, e.imm);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [25:0] dir);
        return {6'h02, dir};
    endfunction

    task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        i_wb_write_en = en;
        i_wb_addr     = addr;
        i_wb_data     = data;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_instruction = '0; i_next_seq_pc = '0; i_mem_reg_write = 1'b0; i_mem_dst = '0;
        wb(1'b0, 5'd0, 32'd0);

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 32'(o_ex_valid), 32'd0);
        chk("rst_bus_a", o_ex_bus_a, 32'd0);
        chk("rst_imm", o_ex_imm, 32'd0);
        chk("rst_dst", 32'(o_ex_dst), 32'd0);
        chk("rst_reg_write", 32'(o_ex_reg_write), 32'd0);
        chk("rst_mem_read", 32'(o_ex_mem_read), 32'd0);
        chk("rst_hazard", 32'(o_hazard_stall), 32'd0);
        chk("rst_taken", 32'(o_branch_taken), 32'd0);
        i_reset = 1'b0;

        // BEQ with equal operands written through WB
        wb(1'b1, 5'd1, 32'd5);
        push_bubble("t1_wb1"); comb("t1_wb1", 1'b0, 1'b0, 1'b0, '0); step();
        wb(1'b1, 5'd2, 32'd5);
        push_bubble("t1_wb2"); comb("t1_wb2", 1'b0, 1'b0, 1'b0, '0); step();
        wb(1'b0, 5'd0, 32'd0);
        i_valid = 1'b1; i_instruction = itype(6'h04, 5'd1, 5'd2, 16'd3); i_next_seq_pc = 32'h40;
        push("t1_beq", 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd2, 32'd5, 32'd5, 32'd3);
        comb("t1_beq", 1'b0, 1'b1, 1'b1, 32'h4C); step();

        // load-use: LW r3 then ADD r4,r3,r1
        i_instruction = itype(6'h23, 5'd1, 5'd3, 16'd0); i_next_seq_pc = 32'h44;
        push("t2_lw", 1'b1, 1'b1, 1'b0, 5'd1, 5'd3, 5'd3, 32'd5, 32'd0, 32'd0);
        comb("t2_lw", 1'b0, 1'b0, 1'b0, '0); step();
        i_instruction = rtype(5'd3, 5'd1, 5'd4, 6'h20); i_next_seq_pc = 32'h48;
        push_bubble("t2_stall"); comb("t2_stall", 1'b1, 1'b0, 1'b0, '0); step();
        push("t2_add", 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 32'h2020);
        comb("t2_add", 1'b0, 1'b0, 1'b0, '0); step();

        // branch operand produced in EX, then in MEM
        i_instruction = itype(6'h08, 5'd0, 5'd5, 16'd1); i_next_seq_pc = 32'h4C;
        push("t3_addi", 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 32'd0, 32'd0, 32'd1);
        comb("t3_addi", 1'b0, 1'b0, 1'b0, '0); step();
        i_instruction = itype(6'h05, 5'd5, 5'd0, 16'd1); i_next_seq_pc = 32'h100;
        i_mem_reg_write = 1'b1; i_mem_dst = 5'd4;
        push_bubble("t3_ex_stall"); comb("t3_ex_stall", 1'b1, 1'b0, 1'b0, '0); step();
        i_mem_dst = 5'd5; wb(1'b1, 5'd5, 32'd1);
        push_bubble("t3_mem_stall"); comb("t3_mem_stall", 1'b1, 1'b0, 1'b0, '0); step();
        i_mem_reg_write = 1'b0; i_mem_dst = 5'd0; wb(1'b0, 5'd0, 32'd0);
        push("t3_bne", 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, 32'd0, 32'd1);
        comb("t3_bne", 1'b0, 1'b1, 1'b1, 32'h104); step();

        // same-cycle WB write of a source register
        i_instruction = rtype(5'd7, 5'd0, 5'd8, 6'h20); i_next_seq_pc = 32'h104;
        wb(1'b1, 5'd7, 32'hDEAD);
`ifdef ID_WB_BYPASS_EN
        push("t4_bypass", 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd8, 32'hDEAD, 32'd0, 32'h4020);
        comb("t4_bypass", 1'b0, 1'b0, 1'b0, '0); step();
        wb(1'b0, 5'd0, 32'd0);
`else
        push_bubble("t4_miss"); comb("t4_miss", 1'b1, 1'b0, 1'b0, '0); step();
        wb(1'b0, 5'd0, 32'd0);
        push("t4_read", 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd8, 32'hDEAD, 32'd0, 32'h4020);
        comb("t4_read", 1'b0, 1'b0, 1'b0, '0); step();
`endif

        // flush beats stall; stall alone holds ID/EX and suppresses J
        i_stall = 1'b1; i_flush = 1'b1;
        i_instruction = jtype(26'h40); i_next_seq_pc = 32'h1000_0010;
        push_bubble("t5_flush"); comb("t5_flush", 1'b0, 1'b0, 1'b0, '0); step();
        i_stall = 1'b0; i_flush = 1'b0;
        push("t5_j", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40);
        comb("t5_j", 1'b0, 1'b1, 1'b1, 32'h1000_0100); step();
        i_stall = 1'b1; i_instruction = jtype(26'h80);
        push("t5_hold", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40);
        comb("t5_hold", 1'b0, 1'b0, 1'b0, '0); step();
        i_stall = 1'b0;

        // r0 stays zero; dst r0 drops reg_write; SW and an undefined opcode
        i_valid = 1'b0; wb(1'b1, 5'd0, 32'hFFFF);
        push_bubble("t6_wb_r0"); comb("t6_wb_r0", 1'b0, 1'b0, 1'b0, '0); step();
        wb(1'b0, 5'd0, 32'd0);
        i_valid = 1'b1; i_instruction = rtype(5'd0, 5'd0, 5'd9, 6'h20);
        push("t6_read_r0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h4820);
        comb("t6_read_r0", 1'b0, 1'b0, 1'b0, '0); step();
        i_instruction = itype(6'h08, 5'd1, 5'd0, 16'hFFFF);
        push("t6_dst0", 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
        comb("t6_dst0", 1'b0, 1'b0, 1'b0, '0); step();
        i_instruction = itype(6'h2B, 5'd1, 5'd2, 16'd4);
        push("t6_sw", 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd2, 32'd5, 32'd5, 32'd4);
        comb("t6_sw", 1'b0, 1'b0, 1'b0, '0); step();
        i_instruction = itype(6'h3F, 5'd2, 5'd6, 16'd7);
        push("t6_nop", 1'b0, 1'b0, 1'b0, 5'd2, 5'd6, 5'd6, 32'd5, 32'd0, 32'd7);
        comb("t6_nop", 1'b0, 1'b0, 1'b0, '0); step();

        // asynchronous reset between edges
        #2;
        i_reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(o_ex_valid), 32'd0);
        chk("t6_async_imm", o_ex_imm, 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_instruction = rtype(5'd1, 5'd2, 5'd10, 6'h20);
        push("t6_bank_clr", 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'd0, 32'd0, 32'h5020);
        comb("t6_bank_clr", 1'b0, 1'b0, 1'b0, '0); step();

        // JR redirects to the register value
        i_valid = 1'b0; wb(1'b1, 5'd1, 32'h200);
        push_bubble("t7_wb"); comb("t7_wb", 1'b0, 1'b0, 1'b0, '0); step();
        wb(1'b0, 5'd0, 32'd0);
        i_valid = 1'b1; i_instruction = rtype(5'd1, 5'd0, 5'd0, 6'h08);
        push("t7_jr", 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h200, 32'd0, 32'd8);
        comb("t7_jr", 1'b0, 1'b1, 1'b1, 32'h200); step();

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0 entries", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
